// File: rtl/lsu_pkg.sv
// Shared constants, FSM state type and legality/alignment helpers for the
// RV32I load/store unit.
package lsu_pkg;

  localparam logic [6:0] MEM_RD_OP = 7'b0000011;
  localparam logic [6:0] MEM_WR_OP = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } lsu_state_t;

  function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
    if (is_store) return f3 inside {F3_B, F3_H, F3_W};
    return f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
  endfunction

  // Size lives in func3[1:0]; only called once func3 is known to be legal.
  function automatic logic addr_aligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b01:   return ~off[0];
      2'b10:   return off == 2'b00;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store byte enables / lane-replicated write data
// and load extraction with sign or zero extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  func3,
  input  logic [1:0]  addr,
  input  logic [31:0] store_data,
  input  logic [31:0] mem_rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] ldata
);

  logic [31:0] shifted;

  always_comb begin
    shifted = mem_rdata >> {addr, 3'b000};
    be      = 4'b1111;
    wdata   = store_data;
    ldata   = shifted;
    case (func3)
      F3_B: begin
        be    = 4'b0001 << addr;
        wdata = {4{store_data[7:0]}};
        ldata = {{24{shifted[7]}}, shifted[7:0]};
      end
      F3_H: begin
        be    = 4'b0011 << addr;
        wdata = {2{store_data[15:0]}};
        ldata = {{16{shifted[15]}}, shifted[15:0]};
      end
      F3_BU:   ldata = {24'b0, shifted[7:0]};
      F3_HU:   ldata = {16'b0, shifted[15:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: issues one request/ready bus transaction per memory
// instruction, stalls the PC while outstanding, flags faults and timeouts.
module lsu
  import lsu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic [2:0]       func3,
  input  logic [WIDTH-1:0] addr,
  input  logic [WIDTH-1:0] store_data,
  output logic             stall,
  output logic [WIDTH-1:0] load_data,
  output logic             load_valid,
  output logic             misaligned,
  output logic             illegal,
  output logic             bus_error,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [3:0]       mem_be,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic             mem_ready,
  input  logic [WIDTH-1:0] mem_rdata
);

  localparam int CW = $clog2(TIMEOUT + 1);

  lsu_state_t     state_q;
  logic [CW-1:0]  cnt_q;
  logic [2:0]     func3_q;
  logic [1:0]     off_q;
  logic           is_store_q;
  logic [WIDTH-1:0] load_data_q, mem_addr_q, mem_wdata_q;
  logic [3:0]     mem_be_q;
  logic           load_valid_q, misaligned_q, illegal_q, bus_error_q, mem_req_q, mem_we_q;

  logic        is_mem_d, is_store_d, legal_d, aligned_d;
  logic [2:0]  al_func3_d;
  logic [1:0]  al_off_d;
  logic [3:0]  be_d;
  logic [31:0] wdata_d, ldata_d;

  assign is_mem_d   = (opcode == MEM_RD_OP) || (opcode == MEM_WR_OP);
  assign is_store_d = (opcode == MEM_WR_OP);
  assign legal_d    = f3_legal(is_store_d, func3);
  assign aligned_d  = addr_aligned(func3, addr[1:0]);

  // Live inputs drive the lane logic while issuing; latched copies afterwards.
  assign al_func3_d = (state_q == IDLE) ? func3 : func3_q;
  assign al_off_d   = (state_q == IDLE) ? addr[1:0] : off_q;

  lsu_align u_align (
    .func3      (al_func3_d),
    .addr       (al_off_d),
    .store_data (store_data),
    .mem_rdata  (mem_rdata),
    .be         (be_d),
    .wdata      (wdata_d),
    .ldata      (ldata_d)
  );

  assign stall = ((state_q == IDLE) && is_mem_d) || (state_q == BUSY);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      func3_q      <= '0;
      off_q        <= '0;
      is_store_q   <= 1'b0;
      load_data_q  <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_be_q     <= '0;
      load_valid_q <= 1'b0;
      misaligned_q <= 1'b0;
      illegal_q    <= 1'b0;
      bus_error_q  <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
    end else begin
      load_valid_q <= 1'b0;
      misaligned_q <= 1'b0;
      illegal_q    <= 1'b0;
      bus_error_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (is_mem_d) begin
            func3_q    <= func3;
            off_q      <= addr[1:0];
            is_store_q <= is_store_d;
            if (!legal_d) begin
              illegal_q <= 1'b1;
              state_q   <= DONE;
            end else if (!aligned_d) begin
              misaligned_q <= 1'b1;
              state_q      <= DONE;
            end else begin
              mem_req_q   <= 1'b1;
              mem_we_q    <= is_store_d;
              mem_addr_q  <= {addr[WIDTH-1:2], 2'b00};
              mem_be_q    <= is_store_d ? be_d : 4'b1111;
              mem_wdata_q <= wdata_d;
              cnt_q       <= '0;
              state_q     <= BUSY;
            end
          end
        end
        BUSY: begin
          // A response on the final allowed cycle still counts as success.
          if (mem_ready) begin
            mem_req_q <= 1'b0;
            if (!is_store_q) begin
              load_data_q  <= ldata_d;
              load_valid_q <= 1'b1;
            end
            state_q <= DONE;
          end else if (cnt_q == CW'(TIMEOUT - 1)) begin
            mem_req_q   <= 1'b0;
            bus_error_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign load_data  = load_data_q;
  assign load_valid = load_valid_q;
  assign misaligned = misaligned_q;
  assign illegal    = illegal_q;
  assign bus_error  = bus_error_q;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_be     = mem_be_q;
  assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_lsu.sv
// Bench for lsu: directed test-plan scenarios plus random memory ops,
// checked against an arithmetic reference model with an expected-load queue.
module tb_lsu;

  localparam int TMO = 4;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_ALU = 7'b0010011;

  // Handshake: a bus request is outstanding while mem_req=1; the transfer
  // completes on the first rising edge where mem_ready=1 with mem_req=1.
  logic        clk, rst;
  logic [6:0]  opcode;
  logic [2:0]  func3;
  logic [31:0] addr, store_data, mem_rdata;
  logic        mem_ready;
  logic        stall, load_valid, misaligned, illegal, bus_error, mem_req, mem_we;
  logic [31:0] load_data, mem_addr, mem_wdata;
  logic [3:0]  mem_be;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total_cnt = 0;
  logic [31:0] exp_q[$];

  lsu #(.WIDTH(32), .TIMEOUT(TMO)) dut (
    .clk        (clk),
    .rst        (rst),
    .opcode     (opcode),
    .func3      (func3),
    .addr       (addr),
    .store_data (store_data),
    .stall      (stall),
    .load_data  (load_data),
    .load_valid (load_valid),
    .misaligned (misaligned),
    .illegal    (illegal),
    .bus_error  (bus_error),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_be     (mem_be),
    .mem_wdata  (mem_wdata),
    .mem_ready  (mem_ready),
    .mem_rdata  (mem_rdata)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard comparisons
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    chk(tag, {31'b0, obs}, {31'b0, exp});
  endtask

  // Reference model: access size in bytes, then plain arithmetic on it.
  function automatic int m_size(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic logic m_legal(input logic st, input logic [2:0] f3);
    if (st) return f3 <= 3'd2;
    return (f3 <= 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
  endfunction

  function automatic logic m_aligned(input logic [2:0] f3, input logic [31:0] a);
    return (int'(a[1:0]) % m_size(f3)) == 0;
  endfunction

  function automatic logic [31:0] m_be(input logic st, input logic [2:0] f3, input logic [1:0] off);
    int v;
    if (!st) return 32'hF;
    v = ((1 << m_size(f3)) - 1) << int'(off);
    return 32'(v & 15);
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] sd);
    case (m_size(f3))
      1:       return {24'b0, sd[7:0]} * 32'h01010101;
      2:       return {16'b0, sd[15:0]} * 32'h00010001;
      default: return sd;
    endcase
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [1:0] off, input logic [31:0] rd);
    logic [31:0] v, b, h;
    v = rd >> (8 * int'(off));
    b = v & 32'hFF;
    h = v & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 32'd128) ? b + 32'hFFFFFF00 : b;
      3'd1:    return (h >= 32'd32768) ? h + 32'hFFFF0000 : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return v;
    endcase
  endfunction

  // Driver: presents one instruction starting from IDLE (just after a falling
  // edge) and leaves the DUT back in IDLE at a falling edge.
  task automatic run_op(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] sd, input logic [31:0] rd, input int wait_n,
                        output logic [31:0] ld, output int stall_n, output int req_n);
    logic mem, st, lgl, aln, is_ld, tmo;
    int busy_n;
    mem    = (op == OP_LD) || (op == OP_ST);
    st     = (op == OP_ST);
    lgl    = m_legal(st, f3);
    aln    = m_aligned(f3, a);
    tmo    = (wait_n >= TMO);
    busy_n = tmo ? TMO : wait_n + 1;
    is_ld  = mem && !st && lgl && aln;
    if (is_ld && !tmo) exp_q.push_back(m_load(f3, a[1:0], rd));
    ld = '0; stall_n = 0; req_n = 0;
    opcode = op; func3 = f3; addr = a; store_data = sd; mem_rdata = rd; mem_ready = 1'b0;
    #1;
    chkb("stall_idle", stall, mem);
    if (stall) stall_n++;
    @(posedge clk); @(negedge clk);
    if (!mem) begin
      chkb("req_nonmem", mem_req, 1'b0);
      chkb("stall_nonmem", stall, 1'b0);
      return;
    end
    if (!lgl || !aln) begin
      chkb("illegal", illegal, !lgl);
      chkb("misaligned", misaligned, lgl && !aln);
      chkb("req_fault", mem_req, 1'b0);
      chkb("lvalid_fault", load_valid, 1'b0);
      chkb("stall_fault_done", stall, 1'b0);
    end else begin
      for (int i = 0; i < busy_n; i++) begin
        chkb("stall_busy", stall, 1'b1);
        if (stall) stall_n++;
        if (mem_req) req_n++;
        chkb("req_busy", mem_req, 1'b1);
        chkb("we", mem_we, st);
        chk("mem_addr", mem_addr, {a[31:2], 2'b00});
        chk("mem_be", {28'b0, mem_be}, m_be(st, f3, a[1:0]));
        if (st) chk("mem_wdata", mem_wdata, m_wdata(f3, sd));
        mem_ready = (i == wait_n);
        @(posedge clk); @(negedge clk);
      end
      mem_ready = 1'b0;
      chkb("req_done", mem_req, 1'b0);
      chkb("stall_done", stall, 1'b0);
      chkb("bus_error", bus_error, tmo);
      chkb("lvalid", load_valid, is_ld && !tmo);
      if (is_ld && !tmo) begin
        ld = load_data;
        chk("load_data", load_data, exp_q.pop_front());
      end
    end
    opcode = OP_ALU;
    @(posedge clk); @(negedge clk);
    chk("pulse_clear", {28'b0, load_valid, misaligned, illegal, bus_error}, 32'd0);
    chkb("stall_idle2", stall, 1'b0);
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_flags"}, {26'b0, mem_req, mem_we, load_valid, misaligned, illegal, bus_error}, 32'd0);
    chk({tag, "_addr"}, mem_addr, 32'd0);
    chk({tag, "_be"}, {28'b0, mem_be}, 32'd0);
    chk({tag, "_wdata"}, mem_wdata, 32'd0);
    chk({tag, "_ldata"}, load_data, 32'd0);
  endtask

  initial begin
    logic [31:0] ld;
    int sn, rn;
    logic [6:0] op;
    logic [2:0] f3;

    rst = 1'b1; opcode = OP_ALU; func3 = '0; addr = '0; store_data = '0;
    mem_rdata = '0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_cleared("reset");
    chkb("reset_stall", stall, 1'b0);
    rst = 1'b0;

    // LW, ready in first BUSY cycle
    run_op(OP_LD, 3'b010, 32'h10001000, 32'h0, 32'hDEADBEEF, 0, ld, sn, rn);
    chk("lw_data", ld, 32'hDEADBEEF);
    chk("lw_stall_cycles", sn, 2);

    // LB / LBU from byte 3
    run_op(OP_LD, 3'b000, 32'h20000003, 32'h0, 32'h80FF7F01, 1, ld, sn, rn);
    chk("lb_data", ld, 32'hFFFFFF80);
    run_op(OP_LD, 3'b100, 32'h20000003, 32'h0, 32'h80FF7F01, 0, ld, sn, rn);
    chk("lbu_data", ld, 32'h00000080);

    // SH upper half, three wait cycles
    run_op(OP_ST, 3'b001, 32'h30000002, 32'h0000ABCD, 32'h0, 3, ld, sn, rn);
    chk("sh_stall_cycles", sn, 5);

    // Misaligned LW
    run_op(OP_LD, 3'b010, 32'h40000006, 32'h0, 32'h12345678, 0, ld, sn, rn);
    chk("mis_stall_cycles", sn, 1);
    chk("mis_req_cycles", rn, 0);

    // Illegal func3 for load and store, illegal beating misaligned
    run_op(OP_LD, 3'b011, 32'h40000000, 32'h0, 32'h0, 0, ld, sn, rn);
    run_op(OP_ST, 3'b100, 32'h40000001, 32'h0, 32'h0, 0, ld, sn, rn);
    run_op(OP_ST, 3'b111, 32'h40000003, 32'h0, 32'h0, 0, ld, sn, rn);

    // Timeout, and ready exactly on the last allowed cycle
    run_op(OP_LD, 3'b010, 32'h50000000, 32'h0, 32'h0, 100, ld, sn, rn);
    chk("tmo_req_cycles", rn, TMO);
    chk("tmo_stall_cycles", sn, TMO + 1);
    run_op(OP_LD, 3'b101, 32'h50000002, 32'h0, 32'hBEEF1234, TMO - 1, ld, sn, rn);
    chk("edge_ready_data", ld, 32'h0000BEEF);

    // Non-memory opcode
    run_op(OP_ALU, 3'b010, 32'h60000000, 32'h0, 32'h0, 0, ld, sn, rn);
    chk("alu_stall_cycles", sn, 0);

    // Reset while BUSY, then a normal LW
    opcode = OP_LD; func3 = 3'b010; addr = 32'h70000010; mem_ready = 1'b0;
    @(posedge clk); @(negedge clk);
    chkb("rst_busy_req", mem_req, 1'b1);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    chk_cleared("midrst");
    opcode = OP_ALU;
    #1;
    chkb("midrst_stall", stall, 1'b0);
    rst = 1'b0;
    @(posedge clk); @(negedge clk);
    run_op(OP_LD, 3'b010, 32'h70000010, 32'h0, 32'hCAFEF00D, 1, ld, sn, rn);
    chk("post_rst_lw", ld, 32'hCAFEF00D);

    // Random ops
    for (int k = 0; k < 60; k++) begin
      case ($urandom_range(0, 3))
        0, 1:    op = OP_LD;
        2:       op = OP_ST;
        default: op = OP_ALU;
      endcase
      f3 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0) f3 = (op == OP_ST) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 5));
      run_op(op, f3, $urandom, $urandom, $urandom, $urandom_range(0, 5), ld, sn, rn);
    end

    chk("exp_q_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
